// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control decoder.
//   - Strobe bit positions for the packed 23-bit one-hot strobe vector.
//   - ALU_target result-select codes.
//   - ctrl_t: the datapath control word, and CTRL_NOP (all controls inactive).
package cpu_ctrl_pkg;

    localparam int unsigned NUM_STROBES = 23;

    // Strobe positions inside the packed strobe vector.
    localparam int unsigned STB_MOV       = 0;
    localparam int unsigned STB_ADDI      = 1;
    localparam int unsigned STB_SUBI      = 2;
    localparam int unsigned STB_LHI       = 3;
    localparam int unsigned STB_LLI       = 4;
    localparam int unsigned STB_LDR       = 5;
    localparam int unsigned STB_STR       = 6;
    localparam int unsigned STB_ADD       = 7;
    localparam int unsigned STB_ADC       = 8;
    localparam int unsigned STB_SUB       = 9;
    localparam int unsigned STB_SBB       = 10;
    localparam int unsigned STB_CMP       = 11;
    localparam int unsigned STB_BCC       = 12;
    localparam int unsigned STB_BCS       = 13;
    localparam int unsigned STB_BNE       = 14;
    localparam int unsigned STB_BEQ       = 15;
    localparam int unsigned STB_BAL       = 16;
    localparam int unsigned STB_JMP       = 17;
    localparam int unsigned STB_JAL_LABEL = 18;
    localparam int unsigned STB_JAL_RM    = 19;
    localparam int unsigned STB_JR        = 20;
    localparam int unsigned STB_OUTR      = 21;
    localparam int unsigned STB_HLT       = 22;

    // ALU result-select codes.
    localparam logic [1:0] TGT_ARITH = 2'b00;
    localparam logic [1:0] TGT_PASSB = 2'b01;
    localparam logic [1:0] TGT_LHI   = 2'b10;
    localparam logic [1:0] TGT_LLI   = 2'b11;

    typedef struct packed {
        logic       rf_rt_addr;
        logic       rf_wr_en;
        logic       rf_wr_from;
        logic       imm5or8;
        logic       jal;
        logic       alu_b;
        logic       alu_op;
        logic       alu_psw;
        logic       memory_wr_en;
        logic [1:0] alu_target;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        rf_rt_addr:   1'b0,
        rf_wr_en:     1'b0,
        rf_wr_from:   1'b0,
        imm5or8:      1'b0,
        jal:          1'b0,
        alu_b:        1'b0,
        alu_op:       1'b0,
        alu_psw:      1'b0,
        memory_wr_en: 1'b0,
        alu_target:   TGT_ARITH
    };

endpackage

// File: rtl/riscv_ctrl_lut.sv
// Combinational strobe-to-control lookup.
// Ports:
//   strobe_i     in  23  packed one-hot op strobes (bit positions from cpu_ctrl_pkg)
//   ctrl_o       out     decoded control word; CTRL_NOP unless exactly one strobe is high
//   onehot_err_o out  1  two or more strobes high
module riscv_ctrl_lut
    import cpu_ctrl_pkg::*;
(
    input  logic [NUM_STROBES-1:0] strobe_i,
    output ctrl_t                  ctrl_o,
    output logic                   onehot_err_o
);

    logic multi_hot;
    logic single_hot;

    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign multi_hot    = |(strobe_i & (strobe_i - NUM_STROBES'(1)));
    assign single_hot   = (|strobe_i) && !multi_hot;
    assign onehot_err_o = multi_hot;

    always_comb begin
        ctrl_o = CTRL_NOP;
        if (single_hot) begin
            unique case (1'b1)
                strobe_i[STB_MOV]: begin
                    ctrl_o.rf_wr_en   = 1'b1;
                    ctrl_o.alu_target = TGT_PASSB;
                end
                strobe_i[STB_ADDI], strobe_i[STB_SUBI]: begin
                    ctrl_o.rf_wr_en = 1'b1;
                    ctrl_o.imm5or8  = 1'b1;
                    ctrl_o.alu_b    = 1'b1;
                    ctrl_o.alu_psw  = 1'b1;
                    ctrl_o.alu_op   = strobe_i[STB_SUBI];
                end
                strobe_i[STB_LHI], strobe_i[STB_LLI]: begin
                    ctrl_o.rf_wr_en   = 1'b1;
                    ctrl_o.imm5or8    = 1'b1;
                    ctrl_o.alu_b      = 1'b1;
                    ctrl_o.alu_target = strobe_i[STB_LLI] ? TGT_LLI : TGT_LHI;
                end
                strobe_i[STB_LDR]: begin
                    ctrl_o.rf_wr_en   = 1'b1;
                    ctrl_o.rf_wr_from = 1'b1;
                    ctrl_o.alu_b      = 1'b1;
                end
                strobe_i[STB_STR]: begin
                    ctrl_o.memory_wr_en = 1'b1;
                    ctrl_o.rf_rt_addr   = 1'b1;
                    ctrl_o.alu_b        = 1'b1;
                end
                strobe_i[STB_ADD], strobe_i[STB_ADC]: begin
                    ctrl_o.rf_wr_en = 1'b1;
                    ctrl_o.alu_psw  = 1'b1;
                end
                strobe_i[STB_SUB], strobe_i[STB_SBB]: begin
                    ctrl_o.rf_wr_en = 1'b1;
                    ctrl_o.alu_psw  = 1'b1;
                    ctrl_o.alu_op   = 1'b1;
                end
                strobe_i[STB_CMP]: begin
                    ctrl_o.alu_psw = 1'b1;
                    ctrl_o.alu_op  = 1'b1;
                end
                strobe_i[STB_BCC], strobe_i[STB_BCS], strobe_i[STB_BNE],
                strobe_i[STB_BEQ], strobe_i[STB_BAL]: begin
                    ctrl_o.imm5or8 = 1'b1;
                end
                strobe_i[STB_JAL_LABEL], strobe_i[STB_JAL_RM]: begin
                    ctrl_o.rf_wr_en = 1'b1;
                    ctrl_o.jal      = 1'b1;
                end
                // JMP, JR, OutR, HLT: control path is idle.
                default: ctrl_o = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/riscv_ctrl_decode.sv
// Main control decoder: registers the decoded control word one cycle after the strobes,
// tracks the sticky halt state and flags non-one-hot strobe vectors.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   MOV .. HLT                 one-hot op strobes from the instruction decoder
//   RF_rt_addr .. ALU_target   registered datapath controls
//   halted                     sticky halt status (cleared only by reset)
//   onehot_err                 previous cycle had two or more strobes high
module riscv_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MOV,
    input  logic       ADDI,
    input  logic       SUBI,
    input  logic       LHI,
    input  logic       LLI,
    input  logic       LDR,
    input  logic       STR,
    input  logic       ADD,
    input  logic       ADC,
    input  logic       SUB,
    input  logic       SBB,
    input  logic       CMP,
    input  logic       BCC,
    input  logic       BCS,
    input  logic       BNE,
    input  logic       BEQ,
    input  logic       BAL,
    input  logic       JMP,
    input  logic       JAL_Label,
    input  logic       JAL_Rm,
    input  logic       JR,
    input  logic       OutR,
    input  logic       HLT,
    output logic       RF_rt_addr,
    output logic       RF_wr_en,
    output logic       RF_wr_from,
    output logic       Imm5or8,
    output logic       JAL,
    output logic       ALU_B,
    output logic       ALU_op,
    output logic       ALU_PSW,
    output logic       Memory_wr_en,
    output logic [1:0] ALU_target,
    output logic       halted,
    output logic       onehot_err
);

    logic [NUM_STROBES-1:0] strobe;
    ctrl_t                  lut_ctrl;
    logic                   lut_err;

    ctrl_t ctrl_d, ctrl_q;
    logic  halted_d, halted_q;
    logic  onehot_err_d, onehot_err_q;

    // Bit order matches the STB_* positions in cpu_ctrl_pkg.
    assign strobe = {HLT, OutR, JR, JAL_Rm, JAL_Label, JMP, BAL, BEQ, BNE, BCS, BCC, CMP,
                     SBB, SUB, ADC, ADD, STR, LDR, LLI, LHI, SUBI, ADDI, MOV};

    riscv_ctrl_lut u_lut (
        .strobe_i     (strobe),
        .ctrl_o       (lut_ctrl),
        .onehot_err_o (lut_err)
    );

    always_comb begin
        ctrl_d       = lut_ctrl;
        onehot_err_d = lut_err;
        halted_d     = halted_q;
        if (halted_q) begin
            // Halted: every strobe is ignored until reset.
            ctrl_d       = CTRL_NOP;
            onehot_err_d = 1'b0;
        end else if (!lut_err && strobe[STB_HLT]) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= CTRL_NOP;
            halted_q     <= 1'b0;
            onehot_err_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            halted_q     <= halted_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign RF_rt_addr   = ctrl_q.rf_rt_addr;
    assign RF_wr_en     = ctrl_q.rf_wr_en;
    assign RF_wr_from   = ctrl_q.rf_wr_from;
    assign Imm5or8      = ctrl_q.imm5or8;
    assign JAL          = ctrl_q.jal;
    assign ALU_B        = ctrl_q.alu_b;
    assign ALU_op       = ctrl_q.alu_op;
    assign ALU_PSW      = ctrl_q.alu_psw;
    assign Memory_wr_en = ctrl_q.memory_wr_en;
    assign ALU_target   = ctrl_q.alu_target;
    assign halted       = halted_q;
    assign onehot_err   = onehot_err_q;

endmodule

// File: tb/tb_riscv_ctrl_decode.sv
// Directed bench for riscv_ctrl_decode. Observed outputs are packed as
// {halted, onehot_err, RF_rt_addr, RF_wr_en, RF_wr_from, Imm5or8, JAL, ALU_B, ALU_op,
//  ALU_PSW, Memory_wr_en, ALU_target[1:0]} and compared with hand-written constants.
module tb_riscv_ctrl_decode;

    logic        clk;
    logic        rst_n;
    logic [22:0] stb;

    logic       RF_rt_addr, RF_wr_en, RF_wr_from, Imm5or8, JAL, ALU_B, ALU_op, ALU_PSW;
    logic       Memory_wr_en, halted, onehot_err;
    logic [1:0] ALU_target;
    logic [12:0] obs;

    int checks;
    int errors;

    // Expected 11-bit control word per strobe, strobe order MOV(0) .. HLT(22).
    logic [10:0] exp_tbl [23];

    riscv_ctrl_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MOV          (stb[0]),
        .ADDI         (stb[1]),
        .SUBI         (stb[2]),
        .LHI          (stb[3]),
        .LLI          (stb[4]),
        .LDR          (stb[5]),
        .STR          (stb[6]),
        .ADD          (stb[7]),
        .ADC          (stb[8]),
        .SUB          (stb[9]),
        .SBB          (stb[10]),
        .CMP          (stb[11]),
        .BCC          (stb[12]),
        .BCS          (stb[13]),
        .BNE          (stb[14]),
        .BEQ          (stb[15]),
        .BAL          (stb[16]),
        .JMP          (stb[17]),
        .JAL_Label    (stb[18]),
        .JAL_Rm       (stb[19]),
        .JR           (stb[20]),
        .OutR         (stb[21]),
        .HLT          (stb[22]),
        .RF_rt_addr   (RF_rt_addr),
        .RF_wr_en     (RF_wr_en),
        .RF_wr_from   (RF_wr_from),
        .Imm5or8      (Imm5or8),
        .JAL          (JAL),
        .ALU_B        (ALU_B),
        .ALU_op       (ALU_op),
        .ALU_PSW      (ALU_PSW),
        .Memory_wr_en (Memory_wr_en),
        .ALU_target   (ALU_target),
        .halted       (halted),
        .onehot_err   (onehot_err)
    );

    assign obs = {halted, onehot_err, RF_rt_addr, RF_wr_en, RF_wr_from, Imm5or8, JAL, ALU_B,
                  ALU_op, ALU_PSW, Memory_wr_en, ALU_target};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive a strobe vector, let one rising edge register it, then sample 1 ns later.
    task automatic step(input string tag, input logic [22:0] s, input logic [12:0] exp);
        stb = s;
        @(posedge clk);
        #1;
        check_val(tag, obs, exp);
    endtask

    initial begin
        //                     rt wr fr im jl b op ps mw tgt
        exp_tbl[0]  = 11'b0_1_0_0_0_0_0_0_0_01; // MOV
        exp_tbl[1]  = 11'b0_1_0_1_0_1_0_1_0_00; // ADDI
        exp_tbl[2]  = 11'b0_1_0_1_0_1_1_1_0_00; // SUBI
        exp_tbl[3]  = 11'b0_1_0_1_0_1_0_0_0_10; // LHI
        exp_tbl[4]  = 11'b0_1_0_1_0_1_0_0_0_11; // LLI
        exp_tbl[5]  = 11'b0_1_1_0_0_1_0_0_0_00; // LDR
        exp_tbl[6]  = 11'b1_0_0_0_0_1_0_0_1_00; // STR
        exp_tbl[7]  = 11'b0_1_0_0_0_0_0_1_0_00; // ADD
        exp_tbl[8]  = 11'b0_1_0_0_0_0_0_1_0_00; // ADC
        exp_tbl[9]  = 11'b0_1_0_0_0_0_1_1_0_00; // SUB
        exp_tbl[10] = 11'b0_1_0_0_0_0_1_1_0_00; // SBB
        exp_tbl[11] = 11'b0_0_0_0_0_0_1_1_0_00; // CMP
        exp_tbl[12] = 11'b0_0_0_1_0_0_0_0_0_00; // BCC
        exp_tbl[13] = 11'b0_0_0_1_0_0_0_0_0_00; // BCS
        exp_tbl[14] = 11'b0_0_0_1_0_0_0_0_0_00; // BNE
        exp_tbl[15] = 11'b0_0_0_1_0_0_0_0_0_00; // BEQ
        exp_tbl[16] = 11'b0_0_0_1_0_0_0_0_0_00; // BAL
        exp_tbl[17] = 11'b0_0_0_0_0_0_0_0_0_00; // JMP
        exp_tbl[18] = 11'b0_1_0_0_1_0_0_0_0_00; // JAL_Label
        exp_tbl[19] = 11'b0_1_0_0_1_0_0_0_0_00; // JAL_Rm
        exp_tbl[20] = 11'b0_0_0_0_0_0_0_0_0_00; // JR
        exp_tbl[21] = 11'b0_0_0_0_0_0_0_0_0_00; // OutR
        exp_tbl[22] = 11'b0_0_0_0_0_0_0_0_0_00; // HLT

        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        stb    = 23'd0;
        stb[7] = 1'b1; // ADD held through reset

        // Reset with ADD active: outputs stay 0 across edges.
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("reset_hold", obs, 13'b0);

        // Release: next edge decodes ADD.
        rst_n = 1'b1;
        step("reset_release_add", 23'd1 << 7, {2'b00, 11'b0_1_0_0_0_0_0_1_0_00});

        // No strobe: NOP, no error.
        step("idle", 23'd0, 13'b0);

        // Single-strobe sweep MOV..OutR.
        for (int i = 0; i < 22; i++) begin
            step($sformatf("sweep_%0d", i), 23'd1 << i, {2'b00, exp_tbl[i]});
        end

        // Explicit STR / LDR / LLI vectors.
        step("str", 23'd1 << 6, {2'b00, 11'b1_0_0_0_0_1_0_0_1_00});
        step("ldr", 23'd1 << 5, {2'b00, 11'b0_1_1_0_0_1_0_0_0_00});
        step("lli", 23'd1 << 4, {2'b00, 11'b0_1_0_1_0_1_0_0_0_11});

        // Multi-hot: ADD+SUB -> NOP with error, then MOV clears it.
        step("multi_add_sub", (23'd1 << 7) | (23'd1 << 9), {2'b01, 11'b0});
        step("after_multi_mov", 23'd1, {2'b00, 11'b0_1_0_0_0_0_0_0_0_01});

        // HLT together with another strobe is ignored.
        step("multi_hlt_mov", (23'd1 << 22) | 23'd1, {2'b01, 11'b0});
        step("not_halted_mov", 23'd1, {2'b00, 11'b0_1_0_0_0_0_0_0_0_01});

        // HLT alone: halted, NOP; strobes then ignored.
        step("hlt", 23'd1 << 22, {2'b10, 11'b0});
        step("halted_mov", 23'd1, {2'b10, 11'b0});
        step("halted_multi", (23'd1 << 7) | (23'd1 << 9), {2'b10, 11'b0});
        step("halted_sub", 23'd1 << 9, {2'b10, 11'b0});

        // Reset pulse clears halted asynchronously; MOV then decodes.
        rst_n = 1'b0;
        #1;
        check_val("halt_reset_async", obs, 13'b0);
        #1 rst_n = 1'b1;
        step("post_halt_mov", 23'd1, {2'b00, 11'b0_1_0_0_0_0_0_0_0_01});

        // Mid-cycle asynchronous reset while SUBI is active.
        step("subi_before_reset", 23'd1 << 2, {2'b00, 11'b0_1_0_1_0_1_1_1_0_00});
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_mid", obs, 13'b0);
        @(posedge clk);
        #1;
        check_val("async_reset_held", obs, 13'b0);
        rst_n = 1'b1;
        step("subi_after_reset", 23'd1 << 2, {2'b00, 11'b0_1_0_1_0_1_1_1_0_00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
